pll_lock_supervisor: RTL and testbench
======================================

// Module: pll_lock_supervisor
// PURPOSE
//  Consumer and controller for the ECP5 EHXPLLL wrapper. Runs on the free-running board clock
//  (12 MHz clkin), drives the PLL RST pin, qualifies the asynchronous LOCK output, and
//  sequences system reset. Retries the PLL on lock timeout and flags a hard fault when retries
//  are exhausted. Consumers in the PLL output domain re-synchronise sys_rst locally.
// PARAMETERS
//  SYNC_STAGES          2       flops in the pll_locked synchroniser (>=2)
//  PLL_RST_CYCLES       12      cycles pll_rst is held high per attempt (1 us @ 12 MHz)
//  LOCK_TIMEOUT_CYCLES  120000  cycles to wait for lock before retrying (10 ms)
//  LOCK_STABLE_CYCLES   1200    consecutive locked cycles required to qualify lock (100 us)
//  RESET_HOLD_CYCLES    16      cycles sys_rst stays high after lock qualifies
//  MAX_RETRIES          3       timeouts before FAULT; 0 = retry forever
// PORTS
//  clk          in   1  free-running reference clock (PLL input clock)
//  rst          in   1  asynchronous, active-high reset
//  pll_locked   in   1  PLL LOCK output, asynchronous to clk
//  pll_rst      out  1  drives PLL RST; high = PLL held in reset
//  sys_rst      out  1  system reset request, active-high
//  ready        out  1  high only in RUN
//  lock_lost    out  1  one-cycle pulse when lock drops while in RUN
//  fault        out  1  sticky; retries exhausted
//  retry_count  out  8  timeouts since last RUN entry, saturates at 255
// BEHAVIOUR
//  Reset: state=PLL_RST, all counters 0, synchroniser 0; pll_rst=1, sys_rst=1, ready=0,
//   lock_lost=0, fault=0, retry_count=0. All outputs registered, no combinational paths.
//  locked_s = output of the SYNC_STAGES-deep synchroniser; only locked_s is used by the FSM.
//  One counter cnt, cleared on every state transition; width is $clog2 of the largest cycle parameter + 1.
//  PLL_RST:   pll_rst=1, sys_rst=1. After PLL_RST_CYCLES cycles -> WAIT_LOCK (pll_rst=0 same edge).
//  WAIT_LOCK: locked_s=1 -> STABLE. If cnt reaches LOCK_TIMEOUT_CYCLES-1 with no lock:
//   retry_count++ (saturating); if MAX_RETRIES!=0 and the new retry_count==MAX_RETRIES -> FAULT,
//   otherwise -> PLL_RST.
//   If locked_s=1 and the timeout coincide, lock wins.
//  STABLE:    stays for LOCK_STABLE_CYCLES cycles with locked_s=1, then -> HOLD.
//   Any locked_s=0 -> WAIT_LOCK with the timeout restarted; retry_count unchanged.
//  HOLD:      sys_rst=1 for RESET_HOLD_CYCLES cycles, then -> RUN.
//   locked_s=0 -> PLL_RST (no lock_lost pulse).
//  RUN:       sys_rst=0, ready=1, retry_count cleared on entry.
//   locked_s=0 -> PLL_RST; on that edge sys_rst=1, ready=0, pll_rst=1, lock_lost=1 for one cycle.
//  FAULT:     pll_rst=0, sys_rst=1, ready=0, fault=1. Terminal until rst.
//  Latency: pll_locked rise -> sys_rst fall = SYNC_STAGES+LOCK_STABLE_CYCLES+RESET_HOLD_CYCLES
//   edges. pll_locked fall in RUN -> sys_rst rise = SYNC_STAGES edges.
//  rst asserted mid-operation returns to reset values immediately (async), including fault.
//  Glitches on pll_locked shorter than one clk period may be missed; this is acceptable.
// TESTING (SYNC=2, PLL_RST=4, TIMEOUT=20, STABLE=8, HOLD=5, MAX_RETRIES=3)
//  Bring-up: release rst, raise pll_locked 2 cycles after pll_rst falls -> pll_rst high exactly
//   4 cycles; sys_rst falls and ready rises 15 edges after pll_locked rise; retry_count=0.
//  Timeout/retry: hold pll_locked=0 -> pll_rst re-pulses every 24 cycles; retry_count 1,2;
//   fault=1 after the 3rd timeout; pll_rst=0, sys_rst=1 thereafter.
//  Unstable lock: toggle pll_locked high for 5 cycles then low in STABLE -> back to WAIT_LOCK,
//   sys_rst stays 1, no lock_lost; then hold high -> RUN reached normally.
//  Lock loss in RUN: drop pll_locked -> sys_rst=1 and ready=0 after 2 edges, lock_lost one-cycle
//   pulse, pll_rst high 4 cycles, then full re-sequence to RUN.
//  Reset mid-HOLD and in FAULT: assert rst -> all outputs return to reset values without a clock
//   edge; fault cleared, retry_count=0.

Source files
------------

// File: rtl/pll_lock_supervisor_if.sv
// Signal bundle between the PLL lock supervisor and the EHXPLLL wrapper / system reset fabric.
// The supervisor owns the master side: it samples pll_locked and drives everything else.
interface pll_lock_supervisor_if;
  logic       pll_locked;
  logic       pll_rst;
  logic       sys_rst;
  logic       ready;
  logic       lock_lost;
  logic       fault;
  logic [7:0] retry_count;

  modport master (
    input  pll_locked,
    output pll_rst,
    output sys_rst,
    output ready,
    output lock_lost,
    output fault,
    output retry_count
  );

  modport slave (
    output pll_locked,
    input  pll_rst,
    input  sys_rst,
    input  ready,
    input  lock_lost,
    input  fault,
    input  retry_count
  );
endinterface

// File: rtl/pll_lock_supervisor.sv
// PLL reset/lock supervisor: pulses PLL RST, qualifies the synchronised LOCK, sequences
// sys_rst, retries on lock timeout and latches a fault once retries run out.
module pll_lock_supervisor #(
  parameter int unsigned SYNC_STAGES         = 2,
  parameter int unsigned PLL_RST_CYCLES      = 12,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 120000,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1200,
  parameter int unsigned RESET_HOLD_CYCLES   = 16,
  parameter int unsigned MAX_RETRIES         = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  pll_lock_supervisor_if.master pll
);

  localparam int unsigned MaxAb  = (PLL_RST_CYCLES > LOCK_TIMEOUT_CYCLES) ?
                                   PLL_RST_CYCLES : LOCK_TIMEOUT_CYCLES;
  localparam int unsigned MaxCd  = (LOCK_STABLE_CYCLES > RESET_HOLD_CYCLES) ?
                                   LOCK_STABLE_CYCLES : RESET_HOLD_CYCLES;
  localparam int unsigned MaxCyc = (MaxAb > MaxCd) ? MaxAb : MaxCd;
  localparam int unsigned CntW   = $clog2(MaxCyc) + 1;

  localparam logic [CntW-1:0] PllRstLast  = CntW'(PLL_RST_CYCLES - 1);
  localparam logic [CntW-1:0] TimeoutLast = CntW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CntW-1:0] StableLast  = CntW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CntW-1:0] HoldLast    = CntW'(RESET_HOLD_CYCLES - 1);

  typedef enum logic [2:0] {
    StPllRst,
    StWaitLock,
    StStable,
    StHold,
    StRun,
    StFault
  } state_e;

  state_e                 state_q;
  logic [CntW-1:0]        cnt_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   locked_s;
  logic                   pll_rst_q;
  logic                   sys_rst_q;
  logic                   ready_q;
  logic                   lock_lost_q;
  logic                   fault_q;
  logic [7:0]             retry_q;
  logic [7:0]             retry_inc;
  logic                   retries_spent;

  // pll_locked is asynchronous to clk; nothing but the last stage may be used downstream.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pll.pll_locked};
    end
  end

  assign locked_s      = sync_q[SYNC_STAGES-1];
  assign retry_inc     = (retry_q == 8'hFF) ? 8'hFF : retry_q + 8'd1;
  assign retries_spent = (MAX_RETRIES != 0) && (32'(retry_inc) == MAX_RETRIES);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StPllRst;
      cnt_q       <= '0;
      pll_rst_q   <= 1'b1;
      sys_rst_q   <= 1'b1;
      ready_q     <= 1'b0;
      lock_lost_q <= 1'b0;
      fault_q     <= 1'b0;
      retry_q     <= '0;
    end else begin
      lock_lost_q <= 1'b0;
      cnt_q       <= cnt_q + CntW'(1);
      unique case (state_q)
        StPllRst: begin
          if (cnt_q == PllRstLast) begin
            state_q   <= StWaitLock;
            cnt_q     <= '0;
            pll_rst_q <= 1'b0;
          end
        end
        StWaitLock: begin
          // A lock arriving on the timeout cycle takes priority over the retry.
          if (locked_s) begin
            state_q <= StStable;
            cnt_q   <= '0;
          end else if (cnt_q == TimeoutLast) begin
            cnt_q   <= '0;
            retry_q <= retry_inc;
            if (retries_spent) begin
              state_q <= StFault;
              fault_q <= 1'b1;
            end else begin
              state_q   <= StPllRst;
              pll_rst_q <= 1'b1;
            end
          end
        end
        StStable: begin
          if (!locked_s) begin
            state_q <= StWaitLock;
            cnt_q   <= '0;
          end else if (cnt_q == StableLast) begin
            state_q <= StHold;
            cnt_q   <= '0;
          end
        end
        StHold: begin
          if (!locked_s) begin
            state_q   <= StPllRst;
            cnt_q     <= '0;
            pll_rst_q <= 1'b1;
          end else if (cnt_q == HoldLast) begin
            state_q   <= StRun;
            cnt_q     <= '0;
            sys_rst_q <= 1'b0;
            ready_q   <= 1'b1;
            retry_q   <= '0;
          end
        end
        StRun: begin
          cnt_q <= '0;
          if (!locked_s) begin
            state_q     <= StPllRst;
            pll_rst_q   <= 1'b1;
            sys_rst_q   <= 1'b1;
            ready_q     <= 1'b0;
            lock_lost_q <= 1'b1;
          end
        end
        StFault: begin
          cnt_q <= '0;
        end
        default: begin
          state_q   <= StPllRst;
          cnt_q     <= '0;
          pll_rst_q <= 1'b1;
          sys_rst_q <= 1'b1;
          ready_q   <= 1'b0;
        end
      endcase
    end
  end

  assign pll.pll_rst     = pll_rst_q;
  assign pll.sys_rst     = sys_rst_q;
  assign pll.ready       = ready_q;
  assign pll.lock_lost   = lock_lost_q;
  assign pll.fault       = fault_q;
  assign pll.retry_count = retry_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Bench for pll_lock_supervisor: directed scenarios push expected output changes (cycle + value)
// into a queue; a monitor compares every observed output change against the queue head.
module tb_pll_lock_supervisor;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   failures;

  pll_lock_supervisor_if bus ();

  pll_lock_supervisor #(
    .SYNC_STAGES        (2),
    .PLL_RST_CYCLES     (4),
    .LOCK_TIMEOUT_CYCLES(20),
    .LOCK_STABLE_CYCLES (8),
    .RESET_HOLD_CYCLES  (5),
    .MAX_RETRIES        (3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .pll(bus)
  );

  typedef struct {
    int          cyc;
    string       name;
    logic [12:0] obs;
  } ev_t;

  ev_t exp_q[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Observation order: pll_rst, sys_rst, ready, lock_lost, fault, retry_count[7:0].
  function automatic logic [12:0] pk(logic pr, logic sr, logic rd, logic ll, logic f,
                                     logic [7:0] rc);
    return {pr, sr, rd, ll, f, rc};
  endfunction

  function automatic logic [12:0] snap();
    return {bus.pll_rst, bus.sys_rst, bus.ready, bus.lock_lost, bus.fault, bus.retry_count};
  endfunction

  task automatic push(input int c, input string n, input logic [12:0] o);
    ev_t e;
    e.cyc  = c;
    e.name = n;
    e.obs  = o;
    exp_q.push_back(e);
  endtask

  task automatic chk_now(input string n, input logic [12:0] want);
    logic [12:0] got;
    got = snap();
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got outputs=%b, want %b", n, got, want);
    end
  endtask

  // Returns at 2 time units after the posedge on which cyc reaches c.
  task automatic wait_to(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Monitor: every change of the output vector is one DUT response.
  initial begin
    logic [12:0] prev;
    logic [12:0] cur;
    ev_t         e;
    @(negedge clk);
    prev = snap();
    forever begin
      @(negedge clk);
      cur = snap();
      if (cur !== prev) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_change: cyc=%0d outputs=%b, want no change", cyc, cur);
        end else begin
          e = exp_q.pop_front();
          if (e.cyc != cyc || e.obs !== cur) begin
            failures++;
            $display("FAIL %s: got cyc=%0d outputs=%b, want cyc=%0d outputs=%b",
                     e.name, cyc, cur, e.cyc, e.obs);
          end
        end
        prev = cur;
      end
    end
  end

  localparam logic [12:0] RstVals = 13'b1_1_0_0_0_00000000;

  initial begin
    int c;
    rst = 1'b1;
    bus.pll_locked = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk_now("reset_state", RstVals);

    // Bring-up: change on the sampling edge s appears at s + 15 for sys_rst/ready.
    c = cyc;
    push(c + 4,  "bringup_pll_rst_fall", pk(0, 1, 0, 0, 0, 8'd0));
    push(c + 22, "bringup_run",          pk(0, 0, 1, 0, 0, 8'd0));
    rst = 1'b0;
    wait_to(c + 6);
    bus.pll_locked = 1'b1;
    wait_to(c + 26);

    // Lock loss in RUN, then full re-sequence.
    c = cyc;
    push(c + 3,  "lockloss_drop",         pk(1, 1, 0, 1, 0, 8'd0));
    push(c + 4,  "lockloss_pulse_end",    pk(1, 1, 0, 0, 0, 8'd0));
    push(c + 7,  "lockloss_pll_rst_fall", pk(0, 1, 0, 0, 0, 8'd0));
    push(c + 24, "lockloss_rerun",        pk(0, 0, 1, 0, 0, 8'd0));
    bus.pll_locked = 1'b0;
    wait_to(c + 8);
    bus.pll_locked = 1'b1;
    wait_to(c + 28);

    // Asynchronous reset while running.
    c = cyc;
    push(c, "rst_in_run", RstVals);
    rst = 1'b1;
    bus.pll_locked = 1'b0;
    #1;
    chk_now("rst_in_run_async", RstVals);
    wait_to(c + 3);

    // Unstable lock: 5 locked cycles in STABLE is not enough to qualify.
    c = cyc;
    push(c + 4,  "unstable_pll_rst_fall", pk(0, 1, 0, 0, 0, 8'd0));
    push(c + 31, "unstable_run",          pk(0, 0, 1, 0, 0, 8'd0));
    rst = 1'b0;
    wait_to(c + 5);
    bus.pll_locked = 1'b1;
    wait_to(c + 10);
    bus.pll_locked = 1'b0;
    wait_to(c + 14);
    chk_now("unstable_back_in_wait", pk(0, 1, 0, 0, 0, 8'd0));
    wait_to(c + 15);
    bus.pll_locked = 1'b1;
    wait_to(c + 34);

    c = cyc;
    push(c, "rst_before_retry", RstVals);
    rst = 1'b1;
    bus.pll_locked = 1'b0;
    wait_to(c + 3);

    // Timeout/retry: 4 + 20 cycles per attempt, fault on the third timeout.
    c = cyc;
    push(c + 4,  "retry_fall0", pk(0, 1, 0, 0, 0, 8'd0));
    push(c + 24, "retry1",      pk(1, 1, 0, 0, 0, 8'd1));
    push(c + 28, "retry_fall1", pk(0, 1, 0, 0, 0, 8'd1));
    push(c + 48, "retry2",      pk(1, 1, 0, 0, 0, 8'd2));
    push(c + 52, "retry_fall2", pk(0, 1, 0, 0, 0, 8'd2));
    push(c + 72, "fault_entry", pk(0, 1, 0, 0, 1, 8'd3));
    rst = 1'b0;
    wait_to(c + 90);
    chk_now("fault_sticky", pk(0, 1, 0, 0, 1, 8'd3));

    c = cyc;
    push(c, "rst_in_fault", RstVals);
    rst = 1'b1;
    #1;
    chk_now("rst_in_fault_async", RstVals);
    wait_to(c + 3);

    // Reset while in HOLD (HOLD spans edges c+16..c+20).
    c = cyc;
    push(c + 4,  "hold_pll_rst_fall", pk(0, 1, 0, 0, 0, 8'd0));
    push(c + 18, "rst_in_hold",       RstVals);
    rst = 1'b0;
    wait_to(c + 5);
    bus.pll_locked = 1'b1;
    wait_to(c + 18);
    rst = 1'b1;
    bus.pll_locked = 1'b0;
    #1;
    chk_now("rst_in_hold_async", RstVals);
    wait_to(c + 24);

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL expected_changes_seen: got %0d missing, want 0", exp_q.size());
      while (exp_q.size() != 0) begin
        ev_t e;
        e = exp_q.pop_front();
        $display("FAIL %s: got no change, want cyc=%0d outputs=%b", e.name, e.cyc, e.obs);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    checks   = 0;
    failures = 0;
  end

endmodule
